bram_stream_reader: RTL and testbench
=====================================

# bram_stream_reader

Read-side client for the common single-port block RAM (1024 x 8, two-cycle registered read, `ena` freezes both read stages). It accepts a command holding a start address and a word count, then issues sequential reads to the RAM. The returned words are presented on a valid/ready stream. Backpressure is applied by deasserting the RAM enable, which freezes the RAM's output pipeline, so no skid buffer is needed. It sits between a scratchpad RAM instance and any streaming consumer, for example weight or activation fetch.

## Interface
- `ADDR_WIDTH`, 10, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8, RAM word width.
- `LEN_WIDTH`, ADDR_WIDTH+1, command length width, so one full RAM pass is expressible.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_addr` in ADDR_WIDTH: start address.
- `cmd_len` in LEN_WIDTH: number of words to read; 0 is legal.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `mem_ena` out 1: RAM enable; also acts as the RAM pipeline advance.
- `mem_wea` out 1: RAM write enable; constant 0.
- `mem_addr` out ADDR_WIDTH: RAM address.
- `mem_din` out DATA_WIDTH: RAM write data; constant 0.
- `mem_dout` in DATA_WIDTH: RAM read data (output of the RAM's second stage).
- `data_out` out DATA_WIDTH / `data_out_valid` out 1 / `data_out_ready` in 1: output stream.
- `busy` out 1: high whenever a command is in progress (state is not IDLE).
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- State machine: IDLE -> RUN on command handshake (`cmd_valid && cmd_ready`). RUN -> IDLE once the remaining count is 0, `v0` = 0, and `v1` = 0 (nothing left to issue, nothing in flight).
- `cmd_ready` = (state == IDLE). Commands are never queued.
- On command accept: latch `cmd_addr` into the address register and `cmd_len` into the remaining counter.
- Two shadow valid bits track the RAM pipeline: `v0` mirrors RAM stage 0 and `v1` mirrors RAM stage 1.
- `adv` = !`v1` || `data_out_ready`.
- `mem_ena` = `adv`, in every state. Enabling the RAM while nothing is in flight is harmless.
- `issue` = `adv` && state == RUN && remaining != 0.
- When `adv` is high: `v1` <= `v0`, and `v0` <= `issue`.
- When `adv` is low: `v0` and `v1` hold. The RAM also holds, because its `ena` is low.
- On `issue`: address increments by 1, wrapping 2^ADDR_WIDTH-1 -> 0, and remaining decrements by 1.
- `mem_addr` = the current address register. Its value is don't-care when not issuing.
- `data_out` = `mem_dout` (combinational passthrough). `data_out_valid` = `v1`.
- `done` pulses in the cycle after the RUN -> IDLE transition condition is met. `busy` is low in that same cycle.
- Zero-length command: RUN lasts one cycle, no reads are issued, and `done` pulses 2 cycles after accept.
- Reset: state IDLE, `v0`=`v1`=0, counters 0.
  - Reset values of outputs: `cmd_ready`=0 during reset and 1 after; `data_out_valid`=0; `busy`=0; `done`=0; `mem_ena`=1 (since `v1`=0).
  - Reset mid-command discards in-flight words. The stale RAM output register is masked by `v1`=0.

## Timing
- Command accepted in cycle T: the first read is issued in T+1, and the first `data_out_valid` appears in T+3 (provided `v1` is empty).
- Throughput is 1 word/cycle while `data_out_ready` is held high.
- Backpressure: if `data_out_valid` && !`data_out_ready`, then `data_out` and `data_out_valid` are held stable in the next cycle, and no new read is issued.
- A word is transferred on any cycle where `data_out_valid` && `data_out_ready`.
- Last handshake of a command in cycle L: `done` = 1 in cycle L+1, and `cmd_ready` = 1 from L+1.
- A new command may be accepted in L+1. Its first data then appears at L+4.

## Test plan
- Basic read: preload RAM[0..3] = 0x10, 0x11, 0x12, 0x13. Send cmd addr=0, len=4 at T with ready always high. Required: data 0x10..0x13 on T+3..T+6; `done` at T+7; `busy` high over T+1..T+6.
- Backpressure: same command, with `data_out_ready` low for 3 cycles after the first valid. Required: 0x10 held stable for 3 cycles, all 4 words delivered exactly once and in order, and `mem_ena` low during the stall.
- Wrap-around: cmd addr=1022, len=4. Required: words read from addresses 1022, 1023, 0, 1, in that order.
- Zero length: cmd len=0. Required: `data_out_valid` never asserted; `done` pulses at T+2; `cmd_ready` high at T+2.
- Reset mid-command: cmd len=8, assert `rst` for 1 cycle after 3 words have been delivered. Required: `data_out_valid`=0 and `busy`=0 the cycle after reset. A subsequent cmd addr=0, len=2 returns RAM[0], RAM[1] only.
- Full pass: cmd addr=0, len=1024 with random ready. Required: 1024 words matching RAM contents in order, exactly one `done` pulse, and `mem_wea` always 0.

Source files
------------

// File: rtl/bram_stream_reader_if.sv
// Bundles the command, block-RAM and output-stream signals of bram_stream_reader.
// The master modport is the reader itself; slave is the surrounding system.
interface bram_stream_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  cmd_valid;
    logic                  cmd_ready;

    logic                  mem_ena;
    logic                  mem_wea;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_ready;

    modport master (
        input  cmd_addr, cmd_len, cmd_valid, mem_dout, data_out_ready,
        output cmd_ready, mem_ena, mem_wea, mem_addr, mem_din,
               data_out, data_out_valid
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_valid, mem_dout, data_out_ready,
        input  cmd_ready, mem_ena, mem_wea, mem_addr, mem_din,
               data_out, data_out_valid
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams a run of sequential words out of a two-stage registered block RAM.
// Backpressure stalls the RAM pipeline through its enable, so no skid buffer exists.
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_stream_reader_if.master bus,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  v0;
    logic                  v1;

    logic adv;
    logic issue;
    logic v0_next;
    logic v1_next;
    logic finish;

    // Completion looks at next-cycle pipeline contents so done lands right after the last handshake.
    always_comb begin
        adv     = !v1 || bus.data_out_ready;
        issue   = adv && (state == RUN) && (remaining != '0);
        v0_next = adv ? issue : v0;
        v1_next = adv ? v0 : v1;
        finish  = (state == RUN) && (remaining == '0) && !v0_next && !v1_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (adv) begin
                v1 <= v0;
                v0 <= issue;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        addr_q    <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q    <= addr_q + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                    end
                    if (finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready      = (state == IDLE) && !rst;
    assign bus.mem_ena        = adv;
    assign bus.mem_wea        = 1'b0;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_din        = '0;
    assign bus.data_out       = bus.mem_dout;
    assign bus.data_out_valid = v1;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader driving a behavioural 1024x8 two-stage RAM.
// Expected words are queued when a command is issued and consumed on each output handshake.
module tb_bram_stream_reader;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int LW = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;
    logic busy;
    logic done;

    bram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.master),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: both read stages freeze while ena is low.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_s0;
    logic [DW-1:0] ram_s1;
    always @(posedge clk) begin
        if (bus.mem_ena) begin
            ram_s0 <= ram[bus.mem_addr];
            ram_s1 <= ram_s0;
        end
    end
    assign bus.mem_dout = ram_s1;

    int compared;
    int mismatched;
    logic [DW-1:0] exp_q [$];
    int rd_idx;
    int xfer_count;
    int done_count;
    int stall_count;
    int ready_mode;

    logic          s_rst, s_valid, s_ready, s_busy, s_done, s_cmd_ready, s_ena, s_wea;
    logic [DW-1:0] s_data;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic monitorCycle();
        s_rst       = rst;
        s_valid     = bus.data_out_valid;
        s_ready     = bus.data_out_ready;
        s_data      = bus.data_out;
        s_busy      = busy;
        s_done      = done;
        s_cmd_ready = bus.cmd_ready;
        s_ena       = bus.mem_ena;
        s_wea       = bus.mem_wea;
        if (s_rst) begin
            rd_idx = exp_q.size();
        end else begin
            checkOutput("mem_wea", s_wea, 0);
            checkOutput("mem_ena", s_ena, !(s_valid && !s_ready));
            if (s_valid) begin
                if (rd_idx < exp_q.size())
                    checkOutput("data", s_data, exp_q[rd_idx]);
                else
                    checkOutput("extra_word", s_valid, 0);
                if (s_ready) begin
                    rd_idx++;
                    xfer_count++;
                end else begin
                    stall_count++;
                end
            end
            if (s_done) done_count++;
        end
    endtask

    // Sample at the falling edge, then drive the next cycle's ready just after the rising edge.
    task automatic stepCycle();
        @(negedge clk);
        monitorCycle();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.data_out_ready = 1'b1;
            1:       bus.data_out_ready = 1'($urandom_range(0, 1));
            default: bus.data_out_ready = 1'b0;
        endcase
    endtask

    task automatic applyStimulus(input int addr, input int len);
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = LW'(len);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < len; i++)
            exp_q.push_back(ram[(addr + i) % DEPTH]);
        stepCycle();
        checkOutput("cmd_ready_at_accept", s_cmd_ready, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int start;
        int n;
        start = done_count;
        n = 0;
        while (done_count == start && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("done_seen", done_count != start, 1);
    endtask

    initial begin
        int base;
        int stalls0;
        int dones0;
        int n;

        compared    = 0;
        mismatched  = 0;
        rd_idx      = 0;
        xfer_count  = 0;
        done_count  = 0;
        stall_count = 0;
        ready_mode  = 0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 37 + 8'h5A);
        ram[0] = 8'h10; ram[1] = 8'h11; ram[2] = 8'h12; ram[3] = 8'h13;

        rst = 1'b1;
        bus.cmd_valid      = 1'b0;
        bus.cmd_addr       = '0;
        bus.cmd_len        = '0;
        bus.data_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset values");
        stepCycle();
        checkOutput("rst_cmd_ready", s_cmd_ready, 0);
        checkOutput("rst_valid", s_valid, 0);
        checkOutput("rst_busy", s_busy, 0);
        checkOutput("rst_done", s_done, 0);
        checkOutput("rst_mem_ena", s_ena, 1);
        rst = 1'b0;
        stepCycle();
        checkOutput("post_rst_cmd_ready", s_cmd_ready, 1);

        $display("[TB] basic read");
        applyStimulus(0, 4);
        for (int k = 1; k <= 7; k++) begin
            stepCycle();
            checkOutput($sformatf("basic_busy_T+%0d", k), s_busy, k <= 6);
            checkOutput($sformatf("basic_valid_T+%0d", k), s_valid, k >= 3 && k <= 6);
            checkOutput($sformatf("basic_done_T+%0d", k), s_done, k == 7);
        end
        checkOutput("basic_cmd_ready_T+7", s_cmd_ready, 1);
        checkOutput("basic_all_delivered", rd_idx, exp_q.size());

        $display("[TB] backpressure");
        ready_mode = 2;
        bus.data_out_ready = 1'b0;
        stalls0 = stall_count;
        applyStimulus(0, 4);
        for (int k = 1; k <= 4; k++) begin
            stepCycle();
            if (k >= 3) checkOutput($sformatf("bp_valid_T+%0d", k), s_valid, 1);
        end
        ready_mode = 0;
        stepCycle();
        checkOutput("bp_valid_T+5", s_valid, 1);
        checkOutput("bp_ena_low_T+5", s_ena, 0);
        waitDone(20);
        checkOutput("bp_stall_cycles", stall_count - stalls0, 3);
        checkOutput("bp_all_delivered", rd_idx, exp_q.size());

        $display("[TB] wrap-around");
        applyStimulus(1022, 4);
        waitDone(20);
        checkOutput("wrap_all_delivered", rd_idx, exp_q.size());

        $display("[TB] zero length");
        applyStimulus(0, 0);
        stepCycle();
        checkOutput("zero_busy_T+1", s_busy, 1);
        checkOutput("zero_done_T+1", s_done, 0);
        checkOutput("zero_cmd_ready_T+1", s_cmd_ready, 0);
        checkOutput("zero_valid_T+1", s_valid, 0);
        stepCycle();
        checkOutput("zero_done_T+2", s_done, 1);
        checkOutput("zero_cmd_ready_T+2", s_cmd_ready, 1);
        checkOutput("zero_busy_T+2", s_busy, 0);
        checkOutput("zero_valid_T+2", s_valid, 0);
        repeat (3) stepCycle();

        $display("[TB] reset mid-command");
        base = xfer_count;
        applyStimulus(0, 8);
        n = 0;
        while (xfer_count < base + 3 && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("midrst_pre_xfers", xfer_count - base, 3);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("midrst_valid_after", s_valid, 0);
        checkOutput("midrst_busy_after", s_busy, 0);
        applyStimulus(0, 2);
        waitDone(20);
        repeat (3) stepCycle();
        checkOutput("midrst_all_delivered", rd_idx, exp_q.size());

        $display("[TB] full pass with random ready");
        ready_mode = 1;
        dones0 = done_count;
        base = xfer_count;
        applyStimulus(0, 1024);
        waitDone(6000);
        ready_mode = 0;
        repeat (4) stepCycle();
        checkOutput("full_words", xfer_count - base, 1024);
        checkOutput("full_done_pulses", done_count - dones0, 1);
        checkOutput("full_all_delivered", rd_idx, exp_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
